// File: rtl/seq_detector_prog.sv
// Programmable serial pattern detector: runtime pattern/length/overlap, saturating match counter.
// Latency: bit accepted at edge N -> seq_detected pulse during cycle N+1 (registered).
// Backpressure: none; every in_valid bit is consumed; a cfg_load in the same cycle discards it.
module seq_detector_prog #(
  parameter int MAX_LEN = 16,
  parameter int LEN_W   = 5,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               in_valid,
  input  logic               in_bit,
  output logic               seq_detected,
  output logic [CNT_W-1:0]   match_count,
  output logic               armed,
  output logic               cfg_err
);

  // IDLE: no usable pattern; FILL: fewer than len bits collected; RUN: window full
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  localparam logic [LEN_W:0] MAX_LEN_C = (LEN_W + 1)'(MAX_LEN);
  localparam logic [LEN_W-1:0] MIN_LEN_C = LEN_W'(2);

  state_t state_q, state_d;

  // Latched configuration. The compare mask is derived once at load time so the
  // per-bit compare is a plain masked equality rather than a variable-width slice.
  logic [MAX_LEN-1:0] pat_q, pat_d;
  logic [MAX_LEN-1:0] mask_q, mask_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               ov_q, ov_d;

  // History keeps only MAX_LEN-1 past bits: together with the incoming bit that
  // forms the full MAX_LEN-wide compare window.
  logic [MAX_LEN-2:0] hist_q, hist_d;
  logic [LEN_W-1:0]   fill_q, fill_d;

  logic               det_d;
  logic [CNT_W-1:0]   cnt_d;
  logic               err_d;

  logic [MAX_LEN-1:0] cfg_mask;
  logic [MAX_LEN-1:0] hist_shift;
  logic [LEN_W:0]     fill_inc;
  logic [LEN_W-1:0]   fill_sat;
  logic               len_legal;
  logic               accept;
  logic               hit;

  // Mask of the low cfg_len bits; pattern bits above len-1 never take part in the compare
  always_comb begin
    cfg_mask = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      cfg_mask[i] = (LEN_W'(i) < cfg_len);
    end
  end

  // Bit acceptance and match decision for the current cycle
  always_comb begin
    len_legal  = (cfg_len >= MIN_LEN_C) && ({1'b0, cfg_len} <= MAX_LEN_C);
    accept     = (state_q != ST_IDLE) && in_valid && !cfg_load;
    hist_shift = {hist_q, in_bit};
    fill_inc   = {1'b0, fill_q} + (LEN_W + 1)'(1);
    fill_sat   = (fill_q < len_q) ? fill_q + LEN_W'(1) : fill_q;
    hit        = accept
              && (fill_inc >= {1'b0, len_q})
              && (((hist_shift ^ pat_q) & mask_q) == '0);
  end

  // Next-state and next-output logic; load beats bit acceptance
  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    mask_d  = mask_q;
    len_d   = len_q;
    ov_d    = ov_q;
    hist_d  = hist_q;
    fill_d  = fill_q;
    det_d   = 1'b0;
    cnt_d   = match_count;
    err_d   = cfg_err;

    if (cfg_load) begin
      hist_d = '0;
      fill_d = '0;
      cnt_d  = '0;
      if (len_legal) begin
        pat_d   = cfg_pattern;
        mask_d  = cfg_mask;
        len_d   = cfg_len;
        ov_d    = cfg_overlap;
        err_d   = 1'b0;
        state_d = ST_FILL;
      end else begin
        err_d   = 1'b1;
        state_d = ST_IDLE;
      end
    end else if (accept) begin
      if (hit) begin
        det_d = 1'b1;
        if (match_count != {CNT_W{1'b1}}) begin
          cnt_d = match_count + CNT_W'(1);
        end
      end
      if (hit && !ov_q) begin
        // Non-overlapping: the next match must be built from len fresh bits
        hist_d  = '0;
        fill_d  = '0;
        state_d = ST_FILL;
      end else begin
        hist_d  = hist_shift[MAX_LEN-2:0];
        fill_d  = fill_sat;
        state_d = (fill_sat == len_q) ? ST_RUN : ST_FILL;
      end
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Configuration, history and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      pat_q        <= '0;
      mask_q       <= '0;
      len_q        <= '0;
      ov_q         <= 1'b0;
      hist_q       <= '0;
      fill_q       <= '0;
      seq_detected <= 1'b0;
      match_count  <= '0;
      armed        <= 1'b0;
      cfg_err      <= 1'b0;
    end else begin
      pat_q        <= pat_d;
      mask_q       <= mask_d;
      len_q        <= len_d;
      ov_q         <= ov_d;
      hist_q       <= hist_d;
      fill_q       <= fill_d;
      seq_detected <= det_d;
      match_count  <= cnt_d;
      armed        <= (state_d != ST_IDLE);
      cfg_err      <= err_d;
    end
  end

endmodule

// File: doc/seq_detector_prog.md
Name: seq_detector_prog

Overview:
- Programmable serial bit-pattern detector; successor to the fixed-pattern detector FSMs in this block family.
- Pattern, pattern length and overlap mode are loaded at run time.
- Serial input is qualified by a valid strobe.
- Each match produces a registered one-cycle pulse and increments a saturating match counter; sits between the serial front end and the control/status logic.

Parameters:
MAX_LEN, 16, maximum pattern length in bits (2..32)
LEN_W, 5, width of cfg_len; must hold MAX_LEN
CNT_W, 8, width of match_count

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous active-high reset
cfg_load  input  1  one-cycle strobe: latch cfg_pattern/cfg_len/cfg_overlap
cfg_pattern  input  MAX_LEN  pattern; bit cfg_len-1 = first bit expected, bit 0 = last
cfg_len  input  LEN_W  pattern length in bits
cfg_overlap  input  1  1 = overlapping matches allowed, 0 = history cleared after each match
in_valid  input  1  in_bit valid this cycle
in_bit  input  1  serial data bit
seq_detected  output  1  one-cycle pulse, registered, one cycle after the matching bit is accepted
match_count  output  CNT_W  saturating count of matches since last load/reset
armed  output  1  valid pattern loaded (state FILL or RUN)
cfg_err  output  1  last load had illegal cfg_len; held until next load or reset

Behaviour:
- Reset (synchronous, reset=1 at clk edge):
  - state=IDLE.
  - Pattern/len/overlap registers, history, fill_cnt, seq_detected, match_count, armed, cfg_err all 0.
  - Reset overrides cfg_load and in_valid in the same cycle.
- States: IDLE (no pattern), FILL (fill_cnt < len), RUN (fill_cnt == len).
- IDLE: in_valid ignored; only cfg_load has effect.
- cfg_load (any state):
  - len legal (2 <= cfg_len <= MAX_LEN): latch config; history=0, fill_cnt=0, match_count=0, seq_detected=0, cfg_err=0; go to FILL.
  - len illegal: go to IDLE, cfg_err=1, match_count=0.
  - cfg_load has priority; an in_valid bit in the same cycle is discarded.
- Bit acceptance (state FILL/RUN, in_valid=1, no cfg_load):
  - hist_next = {hist[MAX_LEN-2:0], in_bit}, newest bit at LSB.
  - fill_cnt increments, saturating at len; FILL->RUN when it reaches len.
  - Match when fill_cnt+1 >= len AND hist_next[len-1:0] == pattern[len-1:0].
- On match:
  - Next cycle seq_detected=1 for exactly one cycle; match_count += 1, saturating at all-ones (no wrap).
  - cfg_overlap=1: history and fill_cnt retained, so overlapping matches are detected.
  - cfg_overlap=0: fill_cnt=0 and history=0 (state->FILL); the next match needs len fresh bits.
- in_valid=0: history, fill_cnt and state hold; seq_detected returns to 0.
- Pattern bits above len-1 are ignored in the compare.
- armed = (state != IDLE), registered.
- Latency: in_bit accepted at edge N -> seq_detected high during cycle N+1. Back-to-back matches give consecutive pulses (len=2, overlap, stream 1111 with pattern 11 -> pulses on bits 2,3,4).

Test Plan:
- Load pattern 0110110, len 7, overlap=1; stream 0110110110 with in_valid=1 -> pulses after bits 7 and 10; match_count=2.
- Same pattern, overlap=0, same stream -> single pulse after bit 7; match_count=1.
- Pattern 0110110, overlap=1; stream 0110110 with in_valid low for 3 cycles between bits 3 and 4 -> single pulse one cycle after bit 7 is accepted, no pulse during the gaps.
- CNT_W=2, pattern 11, len 2, overlap=1; 6 ones -> 5 pulses; match_count sticks at 3.
- cfg_len=1, then cfg_len=MAX_LEN+1 -> cfg_err=1, armed=0, in_valid ignored; then a legal load -> cfg_err=0, armed=1. cfg_load together with in_valid=1 -> bit not entered into history.
- Reset asserted mid-FILL after 4 of 7 bits -> all outputs 0, state IDLE; the remaining 3 bits give no pulse until a reload.
